// File: rtl/jtframe_dwnld_nbank.sv
// jtframe_dwnld_nbank
// Routes the ioctl ROM download byte stream into the SDRAM programming port,
// splitting the address space across up to four SDRAM banks. A small FIFO
// absorbs ioctl bursts while the SDRAM controller is busy, and dwnld_busy
// stays high until every accepted byte has been written.
//
// Optional feature macro: JTFRAME_DWNLD_HEADER_EN
//   When defined, the first HEADER strobes after each download start are
//   skipped and the address is offset by -HEADER before bank decoding.
//
// Ports
//   clk, rst             clock and asynchronous active-high reset
//   downloading          ioctl download window active
//   ioctl_addr/data/wr   ioctl byte stream (wr is a one-cycle strobe)
//   prog_addr/data/mask  SDRAM word address, byte and active-low lane mask
//   prog_bank, prog_we   SDRAM bank and write request (held until prog_rdy)
//   prog_rdy             SDRAM accepted the current write (one-cycle pulse)
//   dwnld_busy           download or SDRAM drain in progress
//   overflow             sticky: a byte was dropped because the FIFO was full
module jtframe_dwnld_nbank #(
  parameter int          BANKS     = 4,
  parameter logic [24:0] BA1_START = 25'h0,
  parameter logic [24:0] BA2_START = 25'h0,
  parameter logic [24:0] BA3_START = 25'h0,
  parameter int          FIFO_AW   = 3,
  parameter int          HEADER    = 0
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 34;  // {bank[1:0], addr[21:0], mask[1:0], data[7:0]}

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  logic              dl_r;
  logic              rise_s;
  logic [24:0]       addr_s;
  logic              hdr_skip_s;
  logic [1:0]        bank_s;
  logic [24:0]       base_s;
  logic [24:0]       off_s;
  logic              s1_valid_r;
  logic [EW-1:0]     s1_entry_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]  cnt_r;
  logic              full_s, pop_s, push_s, drop_s;
  logic [EW-1:0]     head_s, next_s;
  logic              next_avail_s;
  state_t            st_r, st_s;
  logic              we_s;
  logic [EW-1:0]     entry_s;
  logic              unused_s;

  assign rise_s = downloading & ~dl_r;

  // Delayed copy of downloading, used to detect the start of a download
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dl_r <= 1'b0;
    else     dl_r <= downloading;
  end

`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam logic [24:0] HDR = 25'(HEADER);
  logic [24:0] hdr_cnt_r;
  logic [24:0] hdr_eff_s;

  // The counter is cleared on the start edge; a strobe on that same cycle
  // already counts as header byte 0.
  always_comb begin
    hdr_eff_s  = rise_s ? 25'd0 : hdr_cnt_r;
    hdr_skip_s = (hdr_eff_s < HDR);
    addr_s     = ioctl_addr - HDR;
  end

  // Header byte counter, saturating at HEADER
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        hdr_cnt_r <= 25'd0;
    else if (ioctl_wr && downloading && hdr_skip_s) hdr_cnt_r <= hdr_eff_s + 25'd1;
    else if (rise_s)                                hdr_cnt_r <= 25'd0;
    else                                            hdr_cnt_r <= hdr_cnt_r;
  end
`else
  assign hdr_skip_s = 1'b0;
  assign addr_s     = ioctl_addr;
`endif

  // Bank decode: highest enabled bank whose start address is not above addr
  always_comb begin
    bank_s = 2'd0;
    base_s = 25'd0;
    if (BANKS >= 4 && addr_s >= BA3_START) begin
      bank_s = 2'd3; base_s = BA3_START;
    end else if (BANKS >= 3 && addr_s >= BA2_START) begin
      bank_s = 2'd2; base_s = BA2_START;
    end else if (BANKS >= 2 && addr_s >= BA1_START) begin
      bank_s = 2'd1; base_s = BA1_START;
    end else begin
      bank_s = 2'd0; base_s = 25'd0;
    end
    off_s = addr_s - base_s;
  end

  // Offset bits above the 23-bit bank range wrap silently
  assign unused_s = ^{off_s[24:23], 32'(HEADER)};

  // Stage 1: register the decoded entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_entry_r <= '0;
    end else begin
      s1_valid_r <= ioctl_wr & downloading & ~hdr_skip_s;
      if (ioctl_wr && downloading && !hdr_skip_s)
        s1_entry_r <= {bank_s, off_s[22:1], (off_s[0] ? 2'b01 : 2'b10), ioctl_data};
      else
        s1_entry_r <= s1_entry_r;
    end
  end

  // A full FIFO still accepts the push when the head is popped that cycle
  assign full_s = (cnt_r == (FIFO_AW+1)'(DEPTH));
  assign pop_s  = (st_r == WRITE) & prog_rdy;
  assign push_s = s1_valid_r & (~full_s | pop_s);
  assign drop_s = s1_valid_r & full_s & ~pop_s;
  assign head_s = mem_r[rd_ptr_r];

  // With a single stored entry the follow-up can only be the one being pushed
  assign next_s       = (cnt_r > (FIFO_AW+1)'(1)) ? mem_r[rd_ptr_r + FIFO_AW'(1)] : s1_entry_r;
  assign next_avail_s = (cnt_r > (FIFO_AW+1)'(1)) | push_s;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= s1_entry_r;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + FIFO_AW'(push_s);
      rd_ptr_r <= rd_ptr_r + FIFO_AW'(pop_s);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (FIFO_AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (FIFO_AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky overflow flag, cleared when a new download starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         overflow <= 1'b0;
    else if (drop_s) overflow <= 1'b1;
    else if (rise_s) overflow <= 1'b0;
    else             overflow <= overflow;
  end

  // Write FSM: next state and next prog_* values
  always_comb begin
    st_s    = st_r;
    we_s    = prog_we;
    entry_s = {prog_bank, prog_addr, prog_mask, prog_data};
    case (st_r)
      IDLE: begin
        if (cnt_r != '0) begin
          st_s    = WRITE;
          we_s    = 1'b1;
          entry_s = head_s;
        end else begin
          st_s = IDLE;
          we_s = 1'b0;
        end
      end
      WRITE: begin
        if (prog_rdy) begin
          if (next_avail_s) begin
            entry_s = next_s;
            we_s    = 1'b1;
          end else begin
            st_s = IDLE;
            we_s = 1'b0;
          end
        end else begin
          we_s = 1'b1;
        end
      end
      default: begin
        st_s = IDLE;
        we_s = 1'b0;
      end
    endcase
  end

  // Write FSM: state and registered prog_* outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r      <= IDLE;
      prog_we   <= 1'b0;
      prog_bank <= 2'd0;
      prog_addr <= 22'd0;
      prog_mask <= 2'd0;
      prog_data <= 8'd0;
    end else begin
      st_r <= st_s;
      prog_we <= we_s;
      {prog_bank, prog_addr, prog_mask, prog_data} <= entry_s;
    end
  end

  assign dwnld_busy = dl_r | (cnt_r != '0) | prog_we | s1_valid_r;

endmodule

// File: tb/tb_jtframe_dwnld_nbank.sv
module tb_jtframe_dwnld_nbank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        dwnld_busy;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  jtframe_dwnld_nbank #(
    .BANKS(4), .BA1_START(25'h1000), .BA2_START(25'h2000), .BA3_START(25'h3000),
    .FIFO_AW(2), .HEADER(0)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bank thresholds 0x1000/0x2000/0x3000, word address, lane mask
  function automatic logic [33:0] model(input logic [24:0] a, input logic [7:0] d);
    logic [1:0]  b;
    logic [24:0] off;
    if (a >= 25'h3000)      begin b = 2'd3; off = a - 25'h3000; end
    else if (a >= 25'h2000) begin b = 2'd2; off = a - 25'h2000; end
    else if (a >= 25'h1000) begin b = 2'd1; off = a - 25'h1000; end
    else                    begin b = 2'd0; off = a; end
    return {b, off[22:1], (off[0] ? 2'b01 : 2'b10), d};
  endfunction

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic accept);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (accept) exp_q.push_back(model(a, d));
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_head();
    int n = 0;
    logic [33:0] e;
    while (prog_we !== 1'b1 && n < 40) begin tick(); n++; end
    chk("we_timeout", {63'd0, prog_we}, 64'd1);
    if (exp_q.size() == 0) chk("sb_empty", 64'd0, 64'd1);
    else begin
      e = exp_q.pop_front();
      chk("write", {30'd0, prog_bank, prog_addr, prog_mask, prog_data}, {30'd0, e});
    end
  endtask

  task automatic serve(input int delay);
    wait_head();
    repeat (delay) tick();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_outs", {prog_addr, prog_data, prog_mask, prog_bank, prog_we, dwnld_busy, overflow}, 64'd0);
    rst = 1'b0;
    tick();

    // Single byte: latency n+3, fields, release after prog_rdy
    downloading = 1'b1;
    tick();
    ioctl_addr = 25'h5; ioctl_data = 8'hA7; ioctl_wr = 1'b1;
    exp_q.push_back({2'd0, 22'd2, 2'b01, 8'hA7});
    tick();
    ioctl_wr = 1'b0;
    chk("lat_n1", {63'd0, prog_we}, 64'd0);
    tick();
    chk("lat_n2", {63'd0, prog_we}, 64'd0);
    tick();
    chk("lat_n3", {63'd0, prog_we}, 64'd1);
    serve(2);
    chk("we_drop", {63'd0, prog_we}, 64'd0);
    chk("addr_hold", {42'd0, prog_addr}, 64'd2);
    chk("busy_dl", {63'd0, dwnld_busy}, 64'd1);

    // Bank split at the boundaries
    ioctl_addr = 25'h0FFF; ioctl_data = 8'h11; ioctl_wr = 1'b1; tick();
    ioctl_addr = 25'h1000; ioctl_data = 8'h22; tick();
    ioctl_addr = 25'h2001; ioctl_data = 8'h33; tick();
    ioctl_addr = 25'h3004; ioctl_data = 8'h44; tick();
    ioctl_wr = 1'b0;
    exp_q.push_back({2'd0, 22'h7FF, 2'b01, 8'h11});
    exp_q.push_back({2'd1, 22'h000, 2'b10, 8'h22});
    exp_q.push_back({2'd2, 22'h000, 2'b01, 8'h33});
    exp_q.push_back({2'd3, 22'h002, 2'b10, 8'h44});
    repeat (4) serve(1);

    // Overflow: 6 strobes into a 4-entry FIFO with prog_rdy low
    for (int i = 0; i < 6; i++) strobe(25'h10 + 25'(i), 8'h80 + 8'(i), (i < 4));
    repeat (4) tick();
    chk("overflow_set", {63'd0, overflow}, 64'd1);
    repeat (4) serve(0);
    repeat (5) tick();
    chk("dropped_absent", {63'd0, prog_we}, 64'd0);
    downloading = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    tick();
    chk("overflow_clr", {63'd0, overflow}, 64'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) strobe(25'h2040 + 25'(i), 8'h50 + 8'(i), 1'b1);
    wait_head();
    repeat (4) tick();
    ioctl_addr = 25'h3101; ioctl_data = 8'h5F; ioctl_wr = 1'b1;
    exp_q.push_back(model(25'h3101, 8'h5F));
    tick();
    ioctl_wr = 1'b0;
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    chk("fullpop_noovf", {63'd0, overflow}, 64'd0);
    repeat (4) serve(1);
    chk("fullpop_noovf2", {63'd0, overflow}, 64'd0);

    // Drain after downloading falls
    for (int i = 0; i < 3; i++) strobe(25'h1A00 + 25'(i), 8'hC0 + 8'(i), 1'b1);
    repeat (4) tick();
    downloading = 1'b0;
    repeat (3) tick();
    chk("drain_busy", {63'd0, dwnld_busy}, 64'd1);
    serve(1);
    serve(1);
    wait_head();
    prog_rdy = 1'b1;
    chk("drain_busy_last", {63'd0, dwnld_busy}, 64'd1);
    tick();
    prog_rdy = 1'b0;
    chk("drain_busy_fall", {63'd0, dwnld_busy}, 64'd0);
    chk("drain_we_fall", {63'd0, prog_we}, 64'd0);

    // Strobes outside the download window are ignored
    strobe(25'h60, 8'h66, 1'b0);
    repeat (6) tick();
    chk("ignored_we", {63'd0, prog_we}, 64'd0);
    chk("ignored_busy", {63'd0, dwnld_busy}, 64'd0);

    // Reset in the middle of a write discards queued data
    downloading = 1'b1;
    tick();
    strobe(25'h70, 8'h70, 1'b1);
    strobe(25'h71, 8'h71, 1'b0);
    wait_head();
    rst = 1'b1;
    #1;
    chk("rst_async_we", {63'd0, prog_we}, 64'd0);
    tick();
    chk("rst_outs", {prog_addr, prog_data, prog_mask, prog_bank, prog_we, dwnld_busy, overflow}, 64'd0);
    rst = 1'b0;
    tick();
    strobe(25'h2005, 8'h3C, 1'b1);
    serve(1);
    repeat (8) tick();
    chk("rst_fifo_empty", {63'd0, prog_we}, 64'd0);
    downloading = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
